nibble_serial_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit subtractor: Diff = A - B - Bin, computed one 4-bit nibble per clock, LSB nibble first, borrow chained between nibbles.
- Inverse companion to the team's combinational 4-bit adder. The per-nibble datapath is the 4-bit add/subtract slice; a start/busy/done handshake sequences it.
- Used in FPGA test designs (Spartan3E) where wide operands share one narrow arithmetic slice.

---
 rtl/nibble_serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Multi-cycle subtractor: Diff = A - B - Bin (mod 2^WIDTH), produced one 4-bit
// nibble per clock, least-significant nibble first, with the borrow chained
// from nibble to nibble through a register. A single 4-bit subtract slice is
// reused for every nibble; a start/busy/done handshake sequences it.
//
// Parameters
//   WIDTH    operand/result width, multiple of 4 and >= 4
//   NIBBLES  WIDTH/4, number of compute cycles (derived, do not override)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only when not busy (IDLE or DONE)
//   A, B, Bin minuend, subtrahend, borrow-in; latched on accepted start
//   busy      high while an operation is in flight
//   done      one-cycle pulse, results just updated
//   Diff      (A - B - Bin) mod 2^WIDTH
//   Borrow    unsigned borrow-out, 1 iff A < B + Bin
//   Overflow  two's-complement overflow of A - B - Bin
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Overflow
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 4-bit subtract slice: bit 4 of the result is the borrow-out, because
    // a - b - bin lies in [-16, 15] and negative values set the fifth bit.
    function automatic logic [4:0] sub_nibble(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       bin
    );
        logic [4:0] r;
        r = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_w_r;
    logic [WIDTH-1:0] b_w_r;
    logic [WIDTH-1:0] res_r;
    logic             borrow_w_r;

    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [4:0]       slice_s;
    logic [WIDTH-1:0] res_next_s;
    logic             ovf_s;

    // Current-nibble slice and the work result with this nibble merged in.
    always_comb begin
        nib_a_s    = a_w_r[{cnt_r, 2'b00} +: 4];
        nib_b_s    = b_w_r[{cnt_r, 2'b00} +: 4];
        slice_s    = sub_nibble(nib_a_s, nib_b_s, borrow_w_r);
        res_next_s = res_r;
        res_next_s[{cnt_r, 2'b00} +: 4] = slice_s[3:0];
        // Only meaningful on the top nibble: operand signs differ and the
        // result sign departs from the minuend sign.
        ovf_s      = (nib_a_s[3] != nib_b_s[3]) && (slice_s[3] != nib_a_s[3]);
    end

    // Sequencer FSM, work registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            a_w_r      <= {WIDTH{1'b0}};
            b_w_r      <= {WIDTH{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            borrow_w_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            Diff       <= {WIDTH{1'b0}};
            Borrow     <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_w_r      <= A;
                        b_w_r      <= B;
                        borrow_w_r <= Bin;
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= ST_RUN;
                        busy       <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    res_r      <= res_next_s;
                    borrow_w_r <= slice_s[4];
                    cnt_r      <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r  <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        Diff     <= res_next_s;
                        Borrow   <= slice_s[4];
                        Overflow <= ovf_s;
                    end else begin
                        state_r  <= ST_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16). Stimulus pushes the
// expected result of every accepted operation into a queue; a monitor on the
// falling edge pops and compares at each done pulse, checks the adder identity,
// checks output hold between pulses and checks reset values.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrow;
    logic         Overflow;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   hs_mode = 1'b0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .busy     (busy),
        .done     (done),
        .Diff     (Diff),
        .Borrow   (Borrow),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t       e;
        logic [W:0] r;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.a  = a;
        e.b  = b;
        e.bin = bin;
        e.d  = r[W-1:0];
        e.br = r[W];
        e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: reset values, done-pulse scoreboard, output hold, pulse spacing.
    logic [W-1:0] held_d;
    logic         held_b;
    logic         held_o;
    bit           rst_pend = 1'b1;
    int           cyc = 0;
    int           last_done = 0;
    int           hs_cnt = 0;

    always @(negedge clk) begin
        exp_t         e;
        logic [W+1:0] lhs;
        logic [W+1:0] rhs;
        cyc++;
        if (rst_pend) begin
            check("reset_values", {12'd0, busy, done, Borrow, Overflow, Diff}, 32'd0);
            held_d = '0;
            held_b = 1'b0;
            held_o = 1'b0;
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("diff", {16'd0, Diff}, {16'd0, e.d});
                check("borrow", {31'd0, Borrow}, {31'd0, e.br});
                check("overflow", {31'd0, Overflow}, {31'd0, e.ov});
                lhs = {2'b00, Diff} + {2'b00, e.b} + {{(W+1){1'b0}}, e.bin};
                rhs = {2'b00, e.a} + {1'b0, Borrow, {W{1'b0}}};
                check("identity", {14'd0, lhs}, {14'd0, rhs});
                held_d = e.d;
                held_b = e.br;
                held_o = e.ov;
            end
            if (hs_mode) begin
                if (hs_cnt > 0) check("done_spacing", cyc - last_done, 32'd5);
                hs_cnt++;
            end
            last_done = cyc;
        end else begin
            check("hold", {15'd0, Borrow, Overflow, Diff}, {15'd0, held_b, held_o, held_d});
        end
        if (!hs_mode) hs_cnt = 0;
        if (rst_n === 1'b0) begin
            q.delete();
            rst_pend = 1'b1;
        end else begin
            rst_pend = 1'b0;
        end
    end

    // One operation from IDLE: accept, busy for NIBBLES cycles, done, back to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        e.a = a; e.b = b; e.bin = bin; e.d = ed; e.br = eb; e.ov = eo;
        A = a; B = b; Bin = bin; start = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b; Bin = ~bin;   // must not disturb the in-flight result
        for (int i = 0; i < N; i++) begin
            check("busy_run", {30'd0, busy, done}, 32'd2);
            @(posedge clk); #1;
        end
        check("done_pulse", {30'd0, busy, done}, 32'd1);
        @(posedge clk); #1;
        check("idle_after", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, expected values worked by hand.
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // start held high, operands changing every cycle: accepts at edges 0, 5, 10.
        hs_mode = 1'b1;
        start = 1'b1;
        for (int j = 0; j < 15; j++) begin
            A   = 16'(j * 16'h1357 + 16'h0421);
            B   = 16'(j * 16'h2468 + 16'h0111);
            Bin = j[0];
            if (j % 5 == 0) q.push_back(model(A, B, Bin));
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("hs_idle", {30'd0, busy, done}, 32'd0);
        hs_mode = 1'b0;
        check("hs_drained", q.size(), 32'd0);

        // Reset at edge k+2 of an operation: discarded, no done pulse.
        A = 16'h5555; B = 16'h1111; Bin = 1'b0; start = 1'b1;
        q.push_back(model(A, B, Bin));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_busy", {30'd0, busy, done}, 32'd0);
        check("rst_mid_diff", {15'd0, Borrow, Overflow, Diff}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        run_op(16'h4321, 16'h1234, 1'b1, 16'h30EC, 1'b0, 1'b0);

        // Random operands against the reference model plus the identity check.
        for (int k = 0; k < 1000; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            e    = model(ra, rb, rbin);
            run_op(ra, rb, rbin, e.d, e.br, e.ov);
        end

        @(posedge clk); #1;
        check("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
